gpio_bank_mmio: RTL and testbench
=================================

Name: gpio_bank_mmio

Overview:
- Parametrised memory-mapped GPIO peripheral on the CPU's 64-bit IO bus. It supersedes the fixed 16-bit LED register and switch synchroniser.
- Provides a GPIO_W-bit output register, a synchronised and debounced input port, sticky per-bit change flags, and a maskable level interrupt.
- Sits behind the memory-map decoder. It is selected by sel; the local register offset comes from addr[4:3].

Parameters:
- GPIO_W, 16, width of the output and input ports (1..64).
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser chain (>=2).
- DEBOUNCE_CYCLES, 50000, clk cycles between debounce sample ticks (>=2).
- OUT_RESET, 0, reset value of the output register (GPIO_W bits).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- sel, input, 1, address decoder select for this block.
- addr, input, 64, bus address; only bits [4:0] are used.
- addr_valid, input, 1, bus request valid.
- dout_write, input, 1, 1 = write, 0 = read (sampled with addr_valid).
- wdata, input, 64, write data from CPU.
- rdata, output, 64, read data to CPU; valid while ready=1.
- ready, output, 1, one-cycle transaction-complete pulse.
- bus_err, output, 1, one-cycle pulse alongside ready for a misaligned access.
- gpio_out, output, GPIO_W, output register (e.g. LEDs).
- gpio_in, input, GPIO_W, asynchronous inputs (e.g. switches).
- irq, output, 1, level interrupt.

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - gpio_out=OUT_RESET.
  - rdata=0, ready=0, bus_err=0, irq=0.
  - Change flags=0, irq_en=0.
  - Debounced value=0, synchroniser stages=0, prescaler=0.
- Register map (offset addr[4:3]):
  - 0 OUT: RW.
  - 1 IN: RO, debounced value.
  - 2 CHG: sticky change flags; write-1-to-clear.
  - 3 IRQEN: RW mask.
  - Reads zero-extend GPIO_W to 64 bits. Writes use wdata[GPIO_W-1:0]; upper bits are ignored.
- Bus FSM, IDLE/ACK:
  - IDLE: when sel & addr_valid, perform the write or latch rdata, then go to ACK.
  - ACK: ready=1 for exactly one cycle; requests are not sampled in this state; return to IDLE.
  - Latency: valid in cycle N gives ready in cycle N+1. A requester holding valid across ACK starts a new transaction in cycle N+2.
  - Writes to IN, and to any register when dout_write=0, have no side effects.
  - When sel=0, the FSM stays in IDLE and rdata holds its last value.
- Misaligned access (addr[2:0]!=0):
  - No register side effect.
  - rdata=0.
  - ready and bus_err both pulse in the ACK cycle.
- Write timing: a write to OUT is visible on gpio_out in the ACK cycle, i.e. registered on the same edge that enters ACK.
- Synchroniser: gpio_in passes through SYNC_STAGES flops; the output is sync_q.
- Debounce:
  - The prescaler counts 0..DEBOUNCE_CYCLES-1 and wraps; tick=1 when it equals DEBOUNCE_CYCLES-1.
  - On each tick: sample_prev<=sync_q.
  - For each bit where sync_q==sample_prev and differs from the debounced value, update the debounced bit. A bit is therefore accepted after two consecutive agreeing ticks.
  - Glitches shorter than one tick period never propagate.
- Change flags:
  - CHG[i] sets on the cycle debounced[i] changes, in either direction.
  - A W1C write in the same cycle as a set leaves the bit set (set wins).
- Interrupt: irq is registered and equals |(CHG & IRQEN), updated one cycle after CHG or IRQEN changes.
- Reset mid-transaction: the FSM returns to IDLE immediately, ready drops, and no write commits after reset asserts.

Test Plan:
- Reset with GPIO_W=16, OUT_RESET=16'hA5A5 -> gpio_out=A5A5, irq=0, ready=0. Write OUT=64'hFFFF_0000_0000_1234 -> gpio_out=1234 in the ACK cycle; readback=64'h1234; ready high exactly 1 cycle after valid.
- DEBOUNCE_CYCLES=4: drive gpio_in=1234 stable -> IN reads 1234 within SYNC_STAGES+8 cycles, CHG=1234. A 2-cycle pulse on bit 15 -> IN and CHG unchanged for bit 15.
- IRQEN=0x0004 with CHG=1234 -> irq=1 one cycle later. W1C write 0x0004 -> irq=0; CHG=1230.
- Toggle bit 2 so it debounces on the same cycle as a W1C of bit 2 -> CHG[2] stays 1.
- Misaligned read at addr=0x09 -> rdata=0, ready=1 and bus_err=1 in the same cycle. Misaligned write at 0x01 -> gpio_out unchanged.
- Assert rst_n=0 during ACK of a write -> ready=0 at once, gpio_out=OUT_RESET. Back-to-back reads holding valid -> ready pulses at N+1, N+3, ...

Source files
------------

// File: rtl/gpio_bank_mmio.sv
// Memory-mapped GPIO bank: output register, synchronised and debounced inputs,
// sticky change flags with write-1-to-clear, and a maskable level interrupt.
module gpio_bank_mmio #(
   parameter int                GPIO_W          = 16,
   parameter int                SYNC_STAGES     = 2,
   parameter int                DEBOUNCE_CYCLES = 50000,
   parameter logic [GPIO_W-1:0] OUT_RESET       = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel,
   input  logic [63:0]       addr,
   input  logic              addr_valid,
   input  logic              dout_write,
   input  logic [63:0]       wdata,
   output logic [63:0]       rdata,
   output logic              ready,
   output logic              bus_err,
   output logic [GPIO_W-1:0] gpio_out,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic              irq
);

   localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic {IDLE, ACK} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [63:0]       r_rdata;
   logic              r_busErr;
   logic [GPIO_W-1:0] r_out;
   logic [GPIO_W-1:0] r_irqEn;
   logic [GPIO_W-1:0] r_chg;
   logic              r_irq;
   logic [GPIO_W-1:0] r_sync [SYNC_STAGES];
   logic [PW-1:0]     r_pre;
   logic [GPIO_W-1:0] r_samplePrev;
   logic [GPIO_W-1:0] r_deb;

   logic              w_req;
   logic              w_misaligned;
   logic [1:0]        w_off;
   logic              w_wrOk;
   logic [GPIO_W-1:0] w_wdata;
   logic [GPIO_W-1:0] w_chgClr;
   logic [GPIO_W-1:0] w_syncQ;
   logic              w_tick;
   logic [GPIO_W-1:0] w_debChg;
   logic [63:0]       w_rdMux;
   logic              w_unused;

   assign w_req        = (r_state == IDLE) && sel && addr_valid;
   assign w_misaligned = |addr[2:0];
   assign w_off        = addr[4:3];
   assign w_wrOk       = w_req && dout_write && !w_misaligned;
   assign w_wdata      = wdata[GPIO_W-1:0];
   assign w_chgClr     = (w_wrOk && (w_off == 2'd2)) ? w_wdata : '0;
   assign w_syncQ      = r_sync[SYNC_STAGES-1];
   assign w_tick       = (r_pre == PW'(DEBOUNCE_CYCLES - 1));
   assign w_unused     = ^{addr[63:5], wdata};

   // A bit is accepted once two successive ticks agree and differ from the debounced value.
   assign w_debChg = w_tick ? (~(w_syncQ ^ r_samplePrev) & (w_syncQ ^ r_deb)) : '0;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_req) w_next = ACK;
         ACK:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_rdMux = '0;
      case (w_off)
         2'd0: w_rdMux[GPIO_W-1:0] = r_out;
         2'd1: w_rdMux[GPIO_W-1:0] = r_deb;
         2'd2: w_rdMux[GPIO_W-1:0] = r_chg;
         2'd3: w_rdMux[GPIO_W-1:0] = r_irqEn;
         default: w_rdMux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_rdata  <= '0;
         r_busErr <= 1'b0;
         r_out    <= OUT_RESET;
         r_irqEn  <= '0;
      end else begin
         r_state  <= w_next;
         r_busErr <= w_req && w_misaligned;
         if (w_req) begin
            if (w_misaligned)     r_rdata <= '0;
            else if (!dout_write) r_rdata <= w_rdMux;
         end
         if (w_wrOk && (w_off == 2'd0)) r_out   <= w_wdata;
         if (w_wrOk && (w_off == 2'd3)) r_irqEn <= w_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre        <= '0;
         r_samplePrev <= '0;
         r_deb        <= '0;
      end else begin
         r_pre <= w_tick ? '0 : r_pre + PW'(1);
         if (w_tick) r_samplePrev <= w_syncQ;
         r_deb <= r_deb ^ w_debChg;
      end
   end

   // A new change outranks a simultaneous clear of the same bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chg <= '0;
         r_irq <= 1'b0;
      end else begin
         r_chg <= (r_chg & ~w_chgClr) | w_debChg;
         r_irq <= |(r_chg & r_irqEn);
      end
   end

   assign rdata    = r_rdata;
   assign ready    = (r_state == ACK);
   assign bus_err  = r_busErr;
   assign gpio_out = r_out;
   assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_bank_mmio.sv
// Randomised self-checking bench for gpio_bank_mmio against a register-level
// model: the debounced input is expected to follow gpio_in after it settles.
module tb_gpio_bank_mmio;

   localparam int          GPIO_W   = 16;
   localparam int          DEB      = 4;
   localparam logic [15:0] OUTRESET = 16'hA5A5;
   localparam int          SETTLE   = 12;

   logic        clk;
   logic        rst_n;
   logic        sel;
   logic [63:0] addr;
   logic        addr_valid;
   logic        dout_write;
   logic [63:0] wdata;
   logic [63:0] rdata;
   logic        ready;
   logic        bus_err;
   logic [15:0] gpio_out;
   logic [15:0] gpio_in;
   logic        irq;

   int checkCnt = 0;
   int passCnt  = 0;
   int edgeCnt;

   logic [15:0] mOut, mDeb, mChg, mEn;
   logic [63:0] rd;
   logic [15:0] outAck;

   gpio_bank_mmio #(
      .GPIO_W(GPIO_W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .OUT_RESET(OUTRESET)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .addr_valid(addr_valid),
      .dout_write(dout_write), .wdata(wdata), .rdata(rdata), .ready(ready),
      .bus_err(bus_err), .gpio_out(gpio_out), .gpio_in(gpio_in), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; the debounce tick falls on every DEB-th edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edgeCnt <= 0;
      else        edgeCnt <= edgeCnt + 1;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCnt++;
      if (obs === exp) passCnt++;
      else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // One bus transaction; returns rdata and gpio_out as seen in the ACK cycle.
   task automatic applyStimulus(input logic wr, input logic [63:0] a, input logic [63:0] d,
                                output logic [63:0] rdOut, output logic [15:0] outSeen);
      @(negedge clk);
      sel = 1'b1; addr_valid = 1'b1; dout_write = wr; addr = a; wdata = d;
      @(posedge clk); #1;
      checkOutput("ready_ack", 64'(ready), 64'd1);
      checkOutput("bus_err_ack", 64'(bus_err), 64'(a[2:0] != 3'd0));
      rdOut   = rdata;
      outSeen = gpio_out;
      @(negedge clk);
      sel = 1'b0; addr_valid = 1'b0; addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      @(posedge clk); #1;
      checkOutput("ready_drop", 64'(ready), 64'd0);
   endtask

   function automatic logic [63:0] regAddr(input int off);
      logic [63:0] a;
      a = {$urandom, $urandom};
      a[4:0] = {off[1:0], 3'b000};
      return a;
   endfunction

   task automatic settle(input logic [15:0] newIn);
      @(negedge clk);
      gpio_in = newIn;
      repeat (SETTLE) @(posedge clk);
      #1;
      mChg = mChg | (mDeb ^ newIn);
      mDeb = newIn;
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_irq"}, 64'(irq), 64'(|(mChg & mEn)));
      checkOutput({tag, "_gpio_out"}, 64'(gpio_out), 64'(mOut));
   endtask

   initial begin
      logic [15:0] rnd16;
      logic [63:0] rnd64;
      logic [63:0] held;
      int a, t, d, op;

      rst_n = 1'b0; sel = 1'b0; addr = '0; addr_valid = 1'b0;
      dout_write = 1'b0; wdata = '0; gpio_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_gpio_out", 64'(gpio_out), 64'(OUTRESET));
      checkOutput("reset_irq", 64'(irq), 64'd0);
      checkOutput("reset_ready", 64'(ready), 64'd0);
      checkOutput("reset_rdata", rdata, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mOut = OUTRESET; mDeb = '0; mChg = '0; mEn = '0;

      applyStimulus(1'b1, 64'h0, 64'hFFFF_0000_0000_1234, rd, outAck);
      mOut = 16'h1234;
      checkOutput("out_in_ack", 64'(outAck), 64'h1234);
      applyStimulus(1'b0, 64'h0, 64'h0, rd, outAck);
      checkOutput("out_readback", rd, 64'h1234);

      // rdata holds while the block is not selected.
      @(negedge clk); addr_valid = 1'b1; dout_write = 1'b1; addr = 64'h18; wdata = '1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("unsel_rdata_hold", rdata, 64'h1234);
      checkOutput("unsel_ready", 64'(ready), 64'd0);
      @(negedge clk); addr_valid = 1'b0;

      settle(16'h1234);
      applyStimulus(1'b0, 64'h8, 64'h0, rd, outAck);
      checkOutput("in_1234", rd, 64'(mDeb));
      applyStimulus(1'b0, 64'h10, 64'h0, rd, outAck);
      checkOutput("chg_1234", rd, 64'h1234);

      @(negedge clk); gpio_in[15] = 1'b1;
      @(negedge clk);
      @(negedge clk); gpio_in[15] = 1'b0;
      settle(16'h1234);
      applyStimulus(1'b0, 64'h8, 64'h0, rd, outAck);
      checkOutput("glitch_in", rd, 64'h1234);
      applyStimulus(1'b0, 64'h10, 64'h0, rd, outAck);
      checkOutput("glitch_chg", rd, 64'h1234);

      applyStimulus(1'b1, 64'h18, 64'h4, rd, outAck);
      mEn = 16'h0004;
      checkOutput("irq_set", 64'(irq), 64'd1);
      applyStimulus(1'b1, 64'h10, 64'h4, rd, outAck);
      mChg = mChg & ~16'h0004;
      checkOutput("irq_clr", 64'(irq), 64'd0);
      applyStimulus(1'b0, 64'h10, 64'h0, rd, outAck);
      checkOutput("chg_1230", rd, 64'h1230);

      // Land a W1C of bit 2 on the very edge its debounced value flips.
      @(negedge clk);
      gpio_in = 16'h1230;
      a = edgeCnt + 1;
      t = ((a + 2 + DEB - 1) / DEB) * DEB;
      d = t + DEB;
      while (edgeCnt != d - 1) begin
         @(posedge clk); #1;
      end
      applyStimulus(1'b1, 64'h10, 64'h4, rd, outAck);
      mDeb = 16'h1230;
      mChg = 16'h1234;
      applyStimulus(1'b0, 64'h10, 64'h0, rd, outAck);
      checkOutput("set_wins_chg", rd, 64'h1234);
      applyStimulus(1'b0, 64'h8, 64'h0, rd, outAck);
      checkOutput("set_wins_in", rd, 64'h1230);
      checkState("set_wins");

      applyStimulus(1'b0, 64'h9, 64'h0, rd, outAck);
      checkOutput("misaligned_rdata", rd, 64'h0);
      applyStimulus(1'b1, 64'h1, 64'h0000_0000_0000_BEEF, rd, outAck);
      checkOutput("misaligned_wr_out", 64'(gpio_out), 64'(mOut));

      for (int i = 0; i < 40; i++) begin
         op    = int'($urandom_range(0, 7));
         rnd64 = {$urandom, $urandom};
         rnd16 = rnd64[15:0];
         case (op)
            0: begin
               applyStimulus(1'b1, regAddr(0), rnd64, rd, outAck);
               mOut = rnd16;
               checkOutput("rnd_out_ack", 64'(outAck), 64'(mOut));
            end
            1: begin
               applyStimulus(1'b0, regAddr(0), rnd64, rd, outAck);
               checkOutput("rnd_rd_out", rd, 64'(mOut));
            end
            2: begin
               applyStimulus(1'b0, regAddr(1), rnd64, rd, outAck);
               checkOutput("rnd_rd_in", rd, 64'(mDeb));
            end
            3: begin
               applyStimulus(1'b0, regAddr(2), rnd64, rd, outAck);
               checkOutput("rnd_rd_chg", rd, 64'(mChg));
            end
            4: begin
               applyStimulus(1'b1, regAddr(2), rnd64, rd, outAck);
               mChg = mChg & ~rnd16;
            end
            5: begin
               applyStimulus(1'b1, regAddr(3), rnd64, rd, outAck);
               mEn = rnd16;
            end
            6: settle(rnd16);
            default: applyStimulus(1'b1, regAddr(1), rnd64, rd, outAck);
         endcase
         checkState("rnd");
      end
      applyStimulus(1'b0, regAddr(3), 64'h0, rd, outAck);
      checkOutput("rnd_rd_irqen", rd, 64'(mEn));

      @(negedge clk);
      sel = 1'b1; addr_valid = 1'b1; dout_write = 1'b0; addr = 64'h0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checkOutput("b2b_ready", 64'(ready), 64'((i % 2) == 0));
         if ((i % 2) == 0) checkOutput("b2b_rdata", rdata, 64'(mOut));
      end
      @(negedge clk);
      sel = 1'b0; addr_valid = 1'b0;
      @(posedge clk); #1;

      @(negedge clk);
      sel = 1'b1; addr_valid = 1'b1; dout_write = 1'b1; addr = 64'h0; wdata = 64'h5555;
      @(posedge clk); #1;
      held = 64'(ready);
      checkOutput("rst_pre_ready", held, 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_ready", 64'(ready), 64'd0);
      checkOutput("rst_gpio_out", 64'(gpio_out), 64'(OUTRESET));
      checkOutput("rst_irq", 64'(irq), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_hold_out", 64'(gpio_out), 64'(OUTRESET));
      @(negedge clk);
      sel = 1'b0; addr_valid = 1'b0;
      rst_n = 1'b1;
      mOut = OUTRESET; mDeb = '0; mChg = '0; mEn = '0;
      settle(gpio_in);
      applyStimulus(1'b0, 64'h10, 64'h0, rd, outAck);
      checkOutput("post_rst_chg", rd, 64'(mChg));
      applyStimulus(1'b0, 64'h0, 64'h0, rd, outAck);
      checkOutput("post_rst_out", rd, 64'(OUTRESET));
      checkState("post_rst");

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
